// File: rtl/regfile_writeback_queue_if.sv
// Result producers, register-file write port and decode forwarding ports of the writeback queue.
// The master side drives results, stall and read addresses; the queue itself is the slave.
interface regfile_writeback_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             alu_valid_i;
  logic [4:0]       alu_rd_i;
  logic [31:0]      alu_data_i;
  logic             alu_ready_o;
  logic             lsu_valid_i;
  logic [4:0]       lsu_rd_i;
  logic [31:0]      lsu_data_i;
  logic             lsu_ready_o;
  logic             wb_stall_i;
  logic [4:0]       data_write_address_o;
  logic [31:0]      data_in_o;
  logic             write_enable_w_o;
  logic [4:0]       addr_1_i;
  logic [4:0]       addr_2_i;
  logic             hit_1_o;
  logic             hit_2_o;
  logic [31:0]      fwd_1_o;
  logic [31:0]      fwd_2_o;
  logic [CNT_W-1:0] count_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
           wb_stall_i, addr_1_i, addr_2_i,
    input  alu_ready_o, lsu_ready_o, data_write_address_o, data_in_o, write_enable_w_o,
           hit_1_o, hit_2_o, fwd_1_o, fwd_2_o, count_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
           wb_stall_i, addr_1_i, addr_2_i,
    output alu_ready_o, lsu_ready_o, data_write_address_o, data_in_o, write_enable_w_o,
           hit_1_o, hit_2_o, fwd_1_o, fwd_2_o, count_o
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO between ALU/LSU results and the register file write port,
// with forwarding of pending (uncommitted) results to the two decode read ports.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic                      clk_i,
  input logic                      reset_ni,
  regfile_writeback_queue_if.slave wbq
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, alu_ready, lsu_ready, enq, deq;
  entry_t           enq_entry;
  logic [PTR_W-1:0] slot;
  logic             hit_1, hit_2;
  logic [DATA_W-1:0] fwd_1, fwd_2;

  // Full looks only at the current count: a same-cycle drain does not free a slot.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign alu_ready = !full;
  assign lsu_ready = !full && !wbq.alu_valid_i;
  assign deq       = !empty && !wbq.wb_stall_i;

  // ALU has fixed priority; a handshake to x0 completes but enqueues nothing.
  always_comb begin
    enq       = 1'b0;
    enq_entry = '0;
    if (wbq.alu_valid_i) begin
      enq       = alu_ready && (wbq.alu_rd_i != '0);
      enq_entry = '{rd: wbq.alu_rd_i, data: wbq.alu_data_i};
    end else if (wbq.lsu_valid_i) begin
      enq       = lsu_ready && (wbq.lsu_rd_i != '0);
      enq_entry = '{rd: wbq.lsu_rd_i, data: wbq.lsu_data_i};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (enq && !deq)      count_d = count_q + CNT_W'(1);
    else if (!enq && deq) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is deliberately not reset; occupancy is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= enq_entry;
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    fwd_1 = '0;
    fwd_2 = '0;
    slot  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((wbq.addr_1_i != '0) && (mem_q[slot].rd == wbq.addr_1_i)) begin
          hit_1 = 1'b1;
          fwd_1 = mem_q[slot].data;
        end
        if ((wbq.addr_2_i != '0) && (mem_q[slot].rd == wbq.addr_2_i)) begin
          hit_2 = 1'b1;
          fwd_2 = mem_q[slot].data;
        end
      end
    end
  end

  assign wbq.alu_ready_o          = alu_ready;
  assign wbq.lsu_ready_o          = lsu_ready;
  assign wbq.write_enable_w_o     = deq;
  assign wbq.data_write_address_o = empty ? '0 : mem_q[rd_ptr_q].rd;
  assign wbq.data_in_o            = empty ? '0 : mem_q[rd_ptr_q].data;
  assign wbq.hit_1_o              = hit_1;
  assign wbq.hit_2_o              = hit_2;
  assign wbq.fwd_1_o              = fwd_1;
  assign wbq.fwd_2_o              = fwd_2;
  assign wbq.count_o              = count_q;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench: queue-based reference model predicts handshakes, occupancy and
// forwarding; a negedge monitor pops expected commits from a scoreboard.
module tb_regfile_writeback_queue;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk_i;
  logic reset_ni;
  int   tests  = 0;
  int   failed = 0;
  wr_t  pend[$];
  wr_t  exp_q[$];

  regfile_writeback_queue_if #(.DEPTH(DEPTH)) wbq ();
  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (.clk_i(clk_i), .reset_ni(reset_ni), .wbq(wbq));

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Youngest pending write to a nonzero address.
  function automatic void model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 5'd0) begin
      foreach (pend[i]) begin
        if (pend[i].rd == a) begin
          h = 1'b1;
          d = pend[i].data;
        end
      end
    end
  endfunction

  // Commit monitor.
  always @(negedge clk_i) begin
    if (reset_ni === 1'b1 && wbq.write_enable_w_o === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL commit: unexpected write rd=%0d data=0x%08h, expected none",
                 wbq.data_write_address_o, wbq.data_in_o);
      end else begin
        e = exp_q.pop_front();
        chk("commit_rd", 32'(wbq.data_write_address_o), 32'(e.rd));
        chk("commit_data", wbq.data_in_o, e.data);
      end
    end
  end

  // One cycle: called at posedge+1, returns at next posedge+1.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic st, input logic [4:0] a1, input logic [4:0] a2,
                      output logic alu_acc, output logic lsu_acc);
    logic        full, h;
    logic [31:0] d;
    wbq.alu_valid_i = av;  wbq.alu_rd_i = ar;  wbq.alu_data_i = ad;
    wbq.lsu_valid_i = lv;  wbq.lsu_rd_i = lr;  wbq.lsu_data_i = ld;
    wbq.wb_stall_i  = st;  wbq.addr_1_i = a1;  wbq.addr_2_i   = a2;
    #2;
    full = (pend.size() >= DEPTH);
    chk("alu_ready", 32'(wbq.alu_ready_o), 32'(!full));
    chk("lsu_ready", 32'(wbq.lsu_ready_o), 32'(!full && !av));
    chk("count", 32'(wbq.count_o), 32'(pend.size()));
    chk("write_enable", 32'(wbq.write_enable_w_o), 32'(pend.size() != 0 && !st));
    chk("wr_addr", 32'(wbq.data_write_address_o), pend.size() != 0 ? 32'(pend[0].rd) : 32'd0);
    chk("wr_data", wbq.data_in_o, pend.size() != 0 ? pend[0].data : 32'd0);
    model_fwd(a1, h, d);
    chk("hit_1", 32'(wbq.hit_1_o), 32'(h));
    chk("fwd_1", wbq.fwd_1_o, d);
    model_fwd(a2, h, d);
    chk("hit_2", 32'(wbq.hit_2_o), 32'(h));
    chk("fwd_2", wbq.fwd_2_o, d);
    @(posedge clk_i);
    if (pend.size() != 0 && !st) pend.delete(0);
    alu_acc = av && !full;
    lsu_acc = lv && !full && !av;
    if (alu_acc && ar != 5'd0) begin
      pend.push_back('{ar, ad});
      exp_q.push_back('{ar, ad});
    end else if (lsu_acc && lr != 5'd0) begin
      pend.push_back('{lr, ld});
      exp_q.push_back('{lr, ld});
    end
    #1;
  endtask

  task automatic idle(input logic st, input logic [4:0] a1, input logic [4:0] a2);
    logic a, l;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, st, a1, a2, a, l);
  endtask

  // Offer one ALU result until accepted; an exhausted budget is reported by the caller.
  task automatic push_alu(input logic [4:0] rd, input logic [31:0] data, input logic st,
                          input int budget, output logic acc);
    logic a, l;
    acc = 1'b0;
    for (int n = 0; n < budget && !acc; n++) begin
      step(1'b1, rd, data, 1'b0, 5'd0, 32'd0, st, rd, 5'd7, a, l);
      acc = a;
    end
  endtask

  task automatic check_reset(input logic av);
    chk("rst_we", 32'(wbq.write_enable_w_o), 32'd0);
    chk("rst_addr", 32'(wbq.data_write_address_o), 32'd0);
    chk("rst_data", wbq.data_in_o, 32'd0);
    chk("rst_count", 32'(wbq.count_o), 32'd0);
    chk("rst_hit_1", 32'(wbq.hit_1_o), 32'd0);
    chk("rst_hit_2", 32'(wbq.hit_2_o), 32'd0);
    chk("rst_fwd_1", wbq.fwd_1_o, 32'd0);
    chk("rst_fwd_2", wbq.fwd_2_o, 32'd0);
    chk("rst_alu_ready", 32'(wbq.alu_ready_o), 32'd1);
    chk("rst_lsu_ready", 32'(wbq.lsu_ready_o), 32'(!av));
  endtask

  initial begin
    logic a, l, acc;
    int   sent, cyc;

    reset_ni = 1'b0;
    wbq.alu_valid_i = 1'b0; wbq.alu_rd_i = '0; wbq.alu_data_i = '0;
    wbq.lsu_valid_i = 1'b0; wbq.lsu_rd_i = '0; wbq.lsu_data_i = '0;
    wbq.wb_stall_i  = 1'b0; wbq.addr_1_i = 5'd5; wbq.addr_2_i = '0;
    @(posedge clk_i); @(posedge clk_i); #1;
    check_reset(1'b0);
    reset_ni = 1'b1;

    // Single write with one-cycle latency; head entry forwards while being written.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0, a, l);
    idle(1'b0, 5'd5, 5'd0);
    idle(1'b0, 5'd5, 5'd0);

    // ALU priority over LSU, LSU accepted a cycle later.
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd3, 5'd4, a, l);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd3, 5'd4, a, l);
    repeat (3) idle(1'b0, 5'd3, 5'd4);

    // Stall fill: rd1..4 accepted, rd5 held until the first drain.
    for (int i = 1; i <= 4; i++) begin
      push_alu(5'(i), 32'h100 + 32'(i - 1), 1'b1, 2, acc);
      if (!acc) chk("fill_accept_budget", 32'(acc), 32'd1);
    end
    repeat (3) step(1'b1, 5'd5, 32'h104, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd4, a, l);
    push_alu(5'd5, 32'h104, 1'b0, 4, acc);
    if (!acc) chk("release_accept_budget", 32'(acc), 32'd1);
    repeat (6) idle(1'b0, 5'd5, 5'd1);

    // x0 destination is accepted and dropped.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, a, l);
    repeat (2) idle(1'b0, 5'd0, 5'd0);

    // Forwarding picks the youngest of two writes to the same register.
    push_alu(5'd7, 32'hA, 1'b1, 2, acc);
    push_alu(5'd7, 32'hB, 1'b1, 2, acc);
    idle(1'b1, 5'd7, 5'd8);
    repeat (4) idle(1'b0, 5'd7, 5'd8);

    // Asynchronous reset mid-stream with pending entries.
    push_alu(5'd9, 32'h99, 1'b1, 2, acc);
    push_alu(5'd10, 32'hAA, 1'b1, 2, acc);
    wbq.alu_valid_i = 1'b1; wbq.alu_rd_i = 5'd11; wbq.addr_1_i = 5'd9; wbq.addr_2_i = 5'd10;
    reset_ni = 1'b0;
    #1;
    check_reset(1'b1);
    pend.delete();
    exp_q.delete();
    @(posedge clk_i); #1;
    reset_ni = 1'b1;

    // Wrap-around: 12 results, stall every third cycle.
    sent = 0;
    cyc  = 0;
    while (sent < 12 && cyc < 60) begin
      step(1'b1, 5'((sent % 31) + 1), 32'h200 + 32'(sent), 1'b0, 5'd0, 32'd0,
           1'(cyc % 3 == 2), 5'((sent % 31) + 1), 5'd3, a, l);
      if (a) sent++;
      cyc++;
    end
    chk("wrap_sent", 32'(sent), 32'd12);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           a, l);
    end

    repeat (DEPTH + 2) idle(1'b0, 5'd1, 5'd2);
    @(negedge clk_i); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
